// File: rtl/dsa_simd_pkg.sv
// Shared types and constants for the SIMD bilinear fetch unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dsa_simd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

    localparam int FRAC_BITS = 8;

    localparam logic [1:0] NB_P00 = 2'd0;
    localparam logic [1:0] NB_P01 = 2'd1;
    localparam logic [1:0] NB_P10 = 2'd2;
    localparam logic [1:0] NB_P11 = 2'd3;

    // Bit offset of a neighbour byte inside the packed px_out bus.
    function automatic int px_off(input int lane, input int nb);
        return (lane * 4 + nb) * 8;
    endfunction

endpackage

// File: rtl/dsa_src_coord_calc.sv
// Source coordinate pair, weight and lane mask for one output pixel (x or y).
// Latency: combinational.
// Backpressure: none; optional masking under DSA_FETCH_LANE_MASK_EN.
module dsa_src_coord_calc #(
    parameter int FRAC_BITS = 8,
    parameter int LANE      = 0
) (
    input  logic [15:0] base,
    input  logic [15:0] step,
    input  logic [15:0] dim,
    input  logic [15:0] dim_out,
    output logic [15:0] c0,
    output logic [15:0] c1,
    output logic [7:0]  frac,
    output logic        in_range
);

    logic [31:0] pos;
    logic [31:0] s;
    logic [31:0] ipart;
    logic [31:0] lim;
    logic [31:0] c0_w;
    logic [31:0] nxt;
    logic        clamped;

    always_comb begin
        pos     = 32'(base) + 32'(LANE);
        s       = pos * 32'(step);
        ipart   = s >> FRAC_BITS;
        lim     = 32'(dim) - 32'd1;
        clamped = ipart > lim;
        c0_w    = clamped ? lim : ipart;
        nxt     = c0_w + 32'd1;
        c0      = c0_w[15:0];
        c1      = (nxt > lim) ? lim[15:0] : nxt[15:0];
        // A clamped coordinate sits on the edge pixel, so its weight is meaningless.
        frac    = clamped ? 8'd0 : 8'(s & ((32'd1 << FRAC_BITS) - 32'd1));
`ifdef DSA_FETCH_LANE_MASK_EN
        in_range = pos < 32'(dim_out);
`else
        in_range = 1'b1;
`endif
    end

endmodule

// File: rtl/dsa_fetch_unit_simd.sv
// SIMD bilinear neighbour fetch; lane masking selectable with DSA_FETCH_LANE_MASK_EN.
// Latency: fetch_done 3+4*SIMD_WIDTH cycles after fetch_req, fixed.
// Backpressure: none; fetch_req outside IDLE is dropped, busy flags activity.
module dsa_fetch_unit_simd #(
    parameter int SIMD_WIDTH = 4,
    parameter int ADDR_WIDTH = 18,
    parameter int FRAC_BITS  = dsa_simd_pkg::FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_req,
    input  logic [15:0]             current_x,
    input  logic [15:0]             current_y,
    input  logic [15:0]             img_width_in,
    input  logic [15:0]             img_height_in,
    input  logic [15:0]             img_width_out,
    input  logic [15:0]             scale_x,
    input  logic [15:0]             scale_y,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [7:0]              mem_rd_data,
    output logic [SIMD_WIDTH*32-1:0] px_out,
    output logic [SIMD_WIDTH*8-1:0] frac_x_out,
    output logic [7:0]              frac_y_out,
    output logic [SIMD_WIDTH-1:0]   lane_valid,
    output logic                    fetch_done,
    output logic                    busy
);

    import dsa_simd_pkg::*;

    localparam logic [3:0] LAST_SLOT = 4'(4 * SIMD_WIDTH - 1);

    fetch_state_t state, state_nxt;
    logic [3:0]   cnt, cnt_d;
    logic         rd_d;

    logic [15:0] cx_q, cy_q, w_q, h_q, wo_q, scx_q, scy_q;

    logic [15:0]           x0_c [SIMD_WIDTH];
    logic [15:0]           x1_c [SIMD_WIDTH];
    logic [7:0]            fx_c [SIMD_WIDTH];
    logic [SIMD_WIDTH-1:0] ok_c;
    logic [15:0]           y0_c, y1_c;
    logic [7:0]            fy_c;
    logic                  y_ok;

    logic [15:0] x0_q [SIMD_WIDTH];
    logic [15:0] x1_q [SIMD_WIDTH];
    logic [15:0] y0_q, y1_q;

    logic [1:0]  lane, nb;
    logic [15:0] sel_x, sel_y;
    logic [31:0] addr_full;

    for (genvar l = 0; l < SIMD_WIDTH; l++) begin : g_lane
        dsa_src_coord_calc #(.FRAC_BITS(FRAC_BITS), .LANE(l)) u_x (
            .base(cx_q), .step(scx_q), .dim(w_q), .dim_out(wo_q),
            .c0(x0_c[l]), .c1(x1_c[l]), .frac(fx_c[l]), .in_range(ok_c[l])
        );
    end

    dsa_src_coord_calc #(.FRAC_BITS(FRAC_BITS), .LANE(0)) u_y (
        .base(cy_q), .step(scy_q), .dim(h_q), .dim_out(h_q),
        .c0(y0_c), .c1(y1_c), .frac(fy_c), .in_range(y_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cnt_d <= '0;
            rd_d  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_ISSUE && cnt != LAST_SLOT) ? cnt + 4'd1 : 4'd0;
            cnt_d <= cnt;
            rd_d  <= mem_rd_en;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fetch_req) state_nxt = ST_CALC;
            ST_CALC:  state_nxt = ST_ISSUE;
            ST_ISSUE: if (cnt == LAST_SLOT) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Slot counter walks lane-major, neighbours p00,p01,p10,p11 within a lane.
    always_comb begin
        lane      = cnt[3:2];
        nb        = cnt[1:0];
        sel_x     = (nb == NB_P01 || nb == NB_P11) ? x1_q[lane] : x0_q[lane];
        sel_y     = (nb == NB_P10 || nb == NB_P11) ? y1_q : y0_q;
        addr_full = 32'(sel_y) * 32'(w_q) + 32'(sel_x);
        mem_rd_en = (state == ST_ISSUE) && lane_valid[lane];
        mem_addr  = mem_rd_en ? addr_full[ADDR_WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q <= '0; cy_q <= '0; w_q <= '0; h_q <= '0;
            wo_q <= '0; scx_q <= '0; scy_q <= '0;
        end else if (state == ST_IDLE && fetch_req) begin
            cx_q  <= current_x;
            cy_q  <= current_y;
            w_q   <= img_width_in;
            h_q   <= img_height_in;
            wo_q  <= img_width_out;
            scx_q <= scale_x;
            scy_q <= scale_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_out     <= '0;
            frac_x_out <= '0;
            frac_y_out <= '0;
            lane_valid <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            for (int l = 0; l < SIMD_WIDTH; l++) begin
                x0_q[l] <= '0;
                x1_q[l] <= '0;
            end
        end else begin
            case (state)
                ST_CALC: begin
                    px_out     <= '0;
                    frac_y_out <= fy_c;
                    y0_q       <= y0_c;
                    y1_q       <= y1_c;
                    lane_valid <= ok_c;
                    for (int l = 0; l < SIMD_WIDTH; l++) begin
                        x0_q[l]             <= x0_c[l];
                        x1_q[l]             <= x1_c[l];
                        frac_x_out[l*8 +: 8] <= ok_c[l] ? fx_c[l] : 8'd0;
                    end
                end
                ST_ISSUE, ST_DRAIN: begin
                    if (rd_d)
                        px_out[px_off(int'(cnt_d[3:2]), int'(cnt_d[1:0])) +: 8] <= mem_rd_data;
                end
                default: ;
            endcase
        end
    end

    assign fetch_done = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_dsa_fetch_unit_simd.sv
// Scoreboard bench for dsa_fetch_unit_simd: read addresses and completed groups
// are predicted at request time and compared as the DUT produces them.
module tb_dsa_fetch_unit_simd;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_req;
    logic [15:0]  current_x, current_y, img_width_in, img_height_in, img_width_out;
    logic [15:0]  scale_x, scale_y;
    logic         mem_rd_en;
    logic [17:0]  mem_addr;
    logic [7:0]   mem_rd_data;
    logic [127:0] px_out;
    logic [31:0]  frac_x_out;
    logic [7:0]   frac_y_out;
    logic [3:0]   lane_valid;
    logic         fetch_done;
    logic         busy;

    typedef struct {
        logic [127:0] px;
        logic [31:0]  fx;
        logic [7:0]   fy;
        logic [3:0]   lv;
        int           req_cyc;
    } res_t;

    int unsigned exp_addr[$];
    res_t        exp_res[$];
    res_t        mon_r;
    int          vectors  = 0;
    int          errors   = 0;
    int          cycle    = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    dsa_fetch_unit_simd #(.SIMD_WIDTH(N), .ADDR_WIDTH(18), .FRAC_BITS(8)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req),
        .current_x(current_x), .current_y(current_y),
        .img_width_in(img_width_in), .img_height_in(img_height_in),
        .img_width_out(img_width_out), .scale_x(scale_x), .scale_y(scale_y),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .px_out(px_out), .frac_x_out(frac_x_out), .frac_y_out(frac_y_out),
        .lane_valid(lane_valid), .fetch_done(fetch_done), .busy(busy)
    );

    function automatic logic [7:0] pix(input logic [17:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= pix(mem_addr);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_rd_en) begin
            if (exp_addr.size() == 0)
                check("rd_extra", 128'(exp_addr.size()), 128'd1);
            else
                check("rd_addr", 128'(mem_addr), 128'(exp_addr.pop_front()));
        end
        if (!rst && fetch_done) begin
            done_cnt++;
            if (exp_res.size() == 0)
                check("done_extra", 128'(exp_res.size()), 128'd1);
            else begin
                mon_r = exp_res.pop_front();
                check("px_out", px_out, mon_r.px);
                check("frac_x", 128'(frac_x_out), 128'(mon_r.fx));
                check("frac_y", 128'(frac_y_out), 128'(mon_r.fy));
                check("lane_valid", 128'(lane_valid), 128'(mon_r.lv));
                check("latency", 128'(cycle - mon_r.req_cyc), 128'd19);
                check("rd_missing", 128'(exp_addr.size()), 128'd0);
            end
        end
    end

    task automatic fetch(input int unsigned cx, input int unsigned cy, input int unsigned w,
                         input int unsigned h, input int unsigned wo,
                         input int unsigned scx, input int unsigned scy);
        res_t        r;
        int unsigned s, lim, x0, x1, y0, y1, fxv, fyv, a, yy, xx;
        bit          ok;
        r.px = '0; r.fx = '0; r.lv = '0;
        lim = h - 1;
        s   = cy * scy;
        y0  = s >> 8;
        fyv = s & 255;
        if (y0 > lim) begin y0 = lim; fyv = 0; end
        y1  = (y0 + 1 > lim) ? lim : y0 + 1;
        r.fy = 8'(fyv);
        lim = w - 1;
        for (int l = 0; l < N; l++) begin
            s   = (cx + l) * scx;
            x0  = s >> 8;
            fxv = s & 255;
            if (x0 > lim) begin x0 = lim; fxv = 0; end
            x1  = (x0 + 1 > lim) ? lim : x0 + 1;
`ifdef DSA_FETCH_LANE_MASK_EN
            ok = (cx + l) < wo;
`else
            ok = 1'b1;
`endif
            if (ok) begin
                r.lv[l] = 1'b1;
                r.fx[l*8 +: 8] = 8'(fxv);
                for (int k = 0; k < 4; k++) begin
                    yy = (k >= 2) ? y1 : y0;
                    xx = (k % 2 == 1) ? x1 : x0;
                    a  = (yy * w + xx) & 32'h3FFFF;
                    exp_addr.push_back(a);
                    r.px[(l*4+k)*8 +: 8] = pix(18'(a));
                end
            end
        end
        @(posedge clk); #1;
        current_x = 16'(cx); current_y = 16'(cy);
        img_width_in = 16'(w); img_height_in = 16'(h); img_width_out = 16'(wo);
        scale_x = 16'(scx); scale_y = 16'(scy);
        fetch_req = 1'b1;
        r.req_cyc = cycle;
        exp_res.push_back(r);
        @(posedge clk); #1;
        fetch_req = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 40 && done_cnt < target; i++) @(posedge clk);
        #1;
        check("done_timeout", 128'(done_cnt), 128'(target));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, 128'(mem_rd_en), 128'd0);
        check({tag, "_addr"}, 128'(mem_addr), 128'd0);
        check({tag, "_px"}, px_out, 128'd0);
        check({tag, "_fx"}, 128'(frac_x_out), 128'd0);
        check({tag, "_fy"}, 128'(frac_y_out), 128'd0);
        check({tag, "_lv"}, 128'(lane_valid), 128'd0);
        check({tag, "_done"}, 128'(fetch_done), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1; fetch_req = 1'b0;
        current_x = '0; current_y = '0; img_width_in = 16'd8; img_height_in = 16'd8;
        img_width_out = 16'hFFFF; scale_x = '0; scale_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // scale 1.0, 8x8, origin
        fetch(0, 0, 8, 8, 16'hFFFF, 16'h0100, 16'h0100);
        wait_done(1);
        // scale 1.5 interior
        fetch(2, 1, 8, 8, 16'hFFFF, 16'h0180, 16'h0180);
        wait_done(2);
        check("t2_fx_l1", 128'(frac_x_out[15:8]), 128'h80);
        check("t2_fy", 128'(frac_y_out), 128'h80);
        // right/bottom clamp, 4x4
        fetch(2, 3, 4, 4, 16'hFFFF, 16'h0100, 16'h0100);
        wait_done(3);
        check("t3_fx_l2", 128'(frac_x_out[23:16]), 128'h0);
        // output width 6 at x=4: masking only when the feature is built in
        fetch(4, 0, 16, 8, 6, 16'h0100, 16'h0100);
        wait_done(4);
`ifdef DSA_FETCH_LANE_MASK_EN
        check("t4_lv", 128'(lane_valid), 128'h3);
        check("t4_px_hi", 128'(px_out[127:64]), 128'h0);
`else
        check("t4_lv", 128'(lane_valid), 128'hF);
`endif
        // back-to-back right after DONE
        fetch(5, 2, 8, 8, 16'hFFFF, 16'h00C0, 16'h0140);
        wait_done(5);

        // stray request mid-fetch is dropped
        base = done_cnt;
        fetch(1, 1, 8, 8, 16'hFFFF, 16'h0100, 16'h0100);
        repeat (4) @(posedge clk);
        #1 fetch_req = 1'b1;
        @(posedge clk); #1 fetch_req = 1'b0;
        wait_done(base + 1);
        repeat (25) @(posedge clk);
        #1;
        check("stray_done_cnt", 128'(done_cnt), 128'(base + 1));
        check("stray_idle", 128'(busy), 128'd0);

        // reset in cycle 10 aborts the fetch
        base = done_cnt;
        fetch(3, 2, 8, 8, 16'hFFFF, 16'h0100, 16'h0100);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        exp_addr.delete();
        exp_res.delete();
        @(negedge clk);
        check_zero("abort");
        @(posedge clk); #1 rst = 1'b0;
        repeat (25) @(posedge clk);
        #1 check("abort_no_done", 128'(done_cnt), 128'(base));
        fetch(6, 4, 8, 8, 16'hFFFF, 16'h0100, 16'h0100);
        wait_done(base + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dsa_fetch_unit_simd.md
# dsa_fetch_unit_simd

Responder side of the SIMD interpolation control handshake. It accepts a `fetch_req` pulse carrying the base output coordinate of a group of `SIMD_WIDTH` pixels. For each lane it computes the source coordinates, reads the four bilinear neighbours from the source-image RAM through a single synchronous read port, and pulses `fetch_done` when all neighbour pixels and fractional weights are registered for the datapath. It sits between the control FSM, the source-image memory and the interpolation datapath.

## Interface
Parameters:
- `SIMD_WIDTH`, default 4: lanes per group; legal range 1–4.
- `ADDR_WIDTH`, default 18: source RAM address width.
- `FRAC_BITS`, default 8: fractional bits of the scale factors.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `fetch_req`  in  1  one-cycle request pulse; sampled only in IDLE.
- `current_x`, `current_y`  in  16 each  base output coordinate of the group.
- `img_width_in`, `img_height_in`  in  16 each  source dimensions; each ≥ 1.
- `img_width_out`  in  16  output width; used only for lane masking.
- `scale_x`, `scale_y`  in  16 each  source step per output pixel, unsigned Q(16−FRAC_BITS).FRAC_BITS.
- `mem_rd_en`  out  1  read strobe.
- `mem_addr`  out  ADDR_WIDTH  read address.
- `mem_rd_data`  in  8  read data, valid the cycle after `mem_rd_en`.
- `px_out`  out  SIMD_WIDTH*32  neighbour pixels; lane l, neighbour k at bits `[(l*4+k)*8 +: 8]`, with k = 0 p00, 1 p01, 2 p10, 3 p11.
- `frac_x_out`  out  SIMD_WIDTH*8  per-lane x weight, lane l at `[l*8 +: 8]`.
- `frac_y_out`  out  8  y weight, shared by all lanes.
- `lane_valid`  out  SIMD_WIDTH  lanes that hold real pixels.
- `fetch_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE → CALC on `fetch_req`.
  - CALC → ISSUE.
  - ISSUE remains for 4·SIMD_WIDTH cycles, then → DRAIN.
  - DRAIN → DONE.
  - DONE → IDLE.
- CALC latches the inputs and computes the coordinates below for every lane. All arithmetic is unsigned, with 32-bit intermediates.
  - `sx = (current_x + l) * scale_x`
  - `x0 = min(sx >> FRAC_BITS, img_width_in−1)`
  - `x1 = min(x0+1, img_width_in−1)`
  - `fx = sx[FRAC_BITS-1:0]`, forced to 0 when x0 was clamped.
  - y uses the same rules with `current_y`, `scale_y` and `img_height_in`, once per group.
- Address: `y*img_width_in + x`, truncated to ADDR_WIDTH.
- Read order: lane 0 first; within each lane p00 (y0,x0), p01 (y0,x1), p10 (y1,x0), p11 (y1,x1).
- The issue counter advances every ISSUE cycle. A one-cycle-delayed copy of the counter selects the `px_out` byte that captures `mem_rd_data`.
- `px_out`, `frac_*_out` and `lane_valid` are updated only in CALC, ISSUE and DRAIN. They hold their values from DONE until the next request's CALC.
- A `fetch_req` seen outside IDLE is ignored; it is neither queued nor allowed to change state.

## Timing
- Request sampled at edge 0. CALC runs in cycle 1. ISSUE runs in cycles 2 … 1+4N. DRAIN captures the last read in cycle 2+4N. `fetch_done` is high in cycle 3+4N.
  - N=4: `fetch_done` 19 cycles after the request; N=1: 7 cycles.
- Latency is fixed and independent of clamping or masking.
- Back-to-back operation: a `fetch_req` in the cycle after DONE is accepted.
- Reset values: state IDLE; counters 0; `mem_rd_en`, `mem_addr`, `px_out`, `frac_x_out`, `frac_y_out`, `fetch_done`, `busy` all 0; `lane_valid` all 0.
- Reset asserted mid-fetch aborts immediately to the reset values. No `fetch_done` is produced for the aborted request.

## Configuration
- `DSA_FETCH_LANE_MASK_EN` defined:
  - Lane l is valid only if `current_x + l < img_width_out`.
  - For invalid lanes, `mem_rd_en` stays low during that lane's four issue slots, its `px_out` bytes and `frac_x` are set to 0, and `lane_valid[l]` is 0.
  - The issue slots are still consumed, so latency is unchanged.
- Undefined:
  - All lanes read normally; out-of-range x is covered by the clamp.
  - `lane_valid` is all ones after CALC.

## Structure
- Package `dsa_simd_pkg` holds:
  - the state enum;
  - `FRAC_BITS`;
  - neighbour index constants `NB_P00`…`NB_P11`;
  - the `px_out` lane/neighbour bit-offset function.
- Sub-module `dsa_src_coord_calc`: combinational per-lane computation of x0, x1, fx and the lane mask. It is instantiated SIMD_WIDTH times, plus one instance for y.

## Test plan
- Scale 1.0 (0x0100), 8×8 source with pixel = addr, request (0,0), N=4: addresses are lane 0 = 0,1,8,9 … lane 3 = 3,4,11,12; `fetch_done` arrives exactly 19 cycles after the request; all fx = 0.
- Scale 0x0180 (1.5), request (2,1): lane 0 sx = 0x300, giving x0 = 3, fx = 0; lane 1 sx = 0x480, giving x0 = 4, fx = 0x80; y0 = 1, y1 = 2, fy = 0x80.
- Right/bottom edge with 4×4 source, scale 1.0, request (2,3): lane 1 has x0 = x1 = 3; lane 2 has x0 = 3 clamped with fx = 0; y0 = y1 = 3.
- `DSA_FETCH_LANE_MASK_EN` with `img_width_out` = 6 and request (4,0): `lane_valid` = 4'b0011; no `mem_rd_en` in slots 8–15; lanes 2–3 `px_out` = 0.
- `fetch_req` pulsed in cycle 5 of an active fetch: ignored, with exactly one `fetch_done`. Reset asserted in cycle 10: all outputs read 0 the next cycle, and a new request then completes normally.
